// File: rtl/tomasulo_pkg.sv
// Shared ISA constants and the ADD/SUB legality check used by the feeder and the core decoder.
// Pure definitions: no state, no timing, no flow control.
package tomasulo_pkg;

  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [2:0]  F3_ADDSUB = 3'b000;
  localparam logic [6:0]  F7_ADD    = 7'b0000000;
  localparam logic [6:0]  F7_SUB    = 7'b0100000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  function automatic logic is_addsub(input logic [31:0] word);
    return (word[6:0] == OPC_OP) && (word[14:12] == F3_ADDSUB) &&
           ((word[31:25] == F7_ADD) || (word[31:25] == F7_SUB));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, head word readable combinationally; a push is poppable one cycle later.
// Push is ignored when full and pop when empty; a pop never frees a slot for a same-cycle push.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally since DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/tomasulo_instr_feeder.sv
// Buffers loader words, drops non-ADD/SUB, feeds the core one registered word per unstalled cycle.
// Load-to-output latency 2 cycles; load_ready is !full only, stall freezes outputs and pops nothing.
module tomasulo_instr_feeder
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 6,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [31:0]              load_instr,
  output logic                     load_ready,
  input  logic                     stall,
  output logic [31:0]              instr_stream,
  output logic                     instr_valid,
  output logic [PC_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [CNT_W-1:0]         reject_count
);

  logic [31:0]      stream_q, stream_d;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] reject_q, reject_d;
  logic [31:0]      head_dat;
  logic             accept, legal, push, pop;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (load_instr),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign load_ready   = !full;
  assign instr_stream = stream_q;
  assign instr_valid  = valid_q;
  assign instr_pc     = out_pc_q;
  assign reject_count = reject_q;

  always_comb begin
    accept     = load_valid && !full;
    legal      = is_addsub(load_instr);
    push       = accept && legal;
    pop        = !stall && !empty;
    stream_d   = stream_q;
    valid_d    = valid_q;
    out_pc_d   = out_pc_q;
    fetch_pc_d = fetch_pc_q;
    reject_d   = reject_q;
    if (accept && !legal && (reject_q != '1)) reject_d = reject_q + CNT_W'(1);
    if (!stall) begin
      if (!empty) begin
        stream_d   = head_dat;
        valid_d    = 1'b1;
        out_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(4);
      end else begin
        // Bubble: emit a NOP but keep the last PC visible.
        stream_d = NOP_WORD;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stream_q   <= NOP_WORD;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      fetch_pc_q <= '0;
      reject_q   <= '0;
    end else begin
      stream_q   <= stream_d;
      valid_q    <= valid_d;
      out_pc_q   <= out_pc_d;
      fetch_pc_q <= fetch_pc_d;
      reject_q   <= reject_d;
    end
  end

endmodule
